pattern_ack_logger: RTL

- Sits directly downstream of the "boab" pattern detector. Consumes its found_pattern output and drives its ack input.
- Each detected pattern is acknowledged by toggling ack after a programmable delay.
- Each accepted event is counted and timestamped into a small show-ahead FIFO, which a host or debug port reads.
- A handshake that never clears is flagged as a sticky error.

---
 rtl/pattern_ack_logger_pkg.sv | 16 +
 rtl/pattern_ack_logger_ts_fifo.sv | 74 +++++++
 rtl/pattern_ack_logger.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pattern_ack_logger_pkg.sv
// Shared definitions for the pattern detector / ack logger pair.
package pattern_pkg;

  // Handshake FSM states of the ack logger
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DELAY    = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  // ASCII bytes of the "boab" pattern, shared with the detector
  localparam logic [7:0] CHAR_B = 8'd98;
  localparam logic [7:0] CHAR_O = 8'd111;
  localparam logic [7:0] CHAR_A = 8'd97;

endpackage

// File: rtl/pattern_ack_logger_ts_fifo.sv
// Synchronous show-ahead FIFO. dout is a register that always holds the
// current head, so it reads 0 after reset and holds when popped while empty.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module ts_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign valid = (count != {(AW+1){1'b0}});

  // Qualify push/pop: a pop on empty is ignored, a push on full needs a pop
  always_comb begin
    do_pop  = pop & valid;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
      dout   <= {WIDTH{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (do_pop && (count > ONE_CNT)) begin
        dout <= mem[rd_ptr + AW'(1)];
      end else if (do_push && (do_pop || !valid)) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/pattern_ack_logger.sv
// Acknowledges each detection from the pattern detector with a delayed ack
// toggle, counts detections and logs their timestamps into a small FIFO.
module pattern_ack_logger
  import pattern_pkg::*;
#(
  parameter int ACK_DELAY  = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             found_pattern,
  output logic             ack,
  input  logic             clr_stats,
  input  logic             rd_en,
  output logic             ts_valid,
  output logic [TS_W-1:0]  ts_dout,
  output logic             fifo_full,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             timeout_err,
  output logic             busy
);

  // +2 keeps the width at least 1 bit when ACK_DELAY is 0
  localparam int DLY_W = $clog2(ACK_DELAY + 2);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ACK_DELAY);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_next;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_next;
  logic             ack_next;
  logic             accept;
  logic             to_fire;
  logic [TS_W-1:0]  timestamp;
  logic             fifo_drop;

  assign busy = (state != IDLE);

  // Handshake next-state logic: accept, wait ACK_DELAY, toggle, wait for drop
  always_comb begin
    state_next = state;
    dly_next   = dly_cnt;
    to_next    = to_cnt;
    ack_next   = ack;
    accept     = 1'b0;
    to_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (found_pattern) begin
          accept     = 1'b1;
          dly_next   = DLY_LOAD;
          state_next = DELAY;
        end else begin
          state_next = IDLE;
        end
      end
      DELAY: begin
        if (dly_cnt == {DLY_W{1'b0}}) begin
          ack_next   = ~ack;
          to_next    = {TO_W{1'b0}};
          state_next = WAIT_CLR;
        end else begin
          dly_next = dly_cnt - DLY_W'(1);
        end
      end
      WAIT_CLR: begin
        if (!found_pattern) begin
          state_next = IDLE;
        end else if (to_cnt == TO_LAST) begin
          to_fire    = 1'b1;
          state_next = IDLE;
        end else begin
          to_next = to_cnt + TO_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake state, counters and ack register
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state   <= IDLE;
      dly_cnt <= {DLY_W{1'b0}};
      to_cnt  <= {TO_W{1'b0}};
      ack     <= 1'b0;
    end else begin
      state   <= state_next;
      dly_cnt <= dly_next;
      to_cnt  <= to_next;
      ack     <= ack_next;
    end
  end

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      timestamp <= {TS_W{1'b0}};
    end else begin
      timestamp <= timestamp + TS_W'(1);
    end
  end

  // Statistics: clear has priority over any same-cycle update
  always_ff @(posedge clk) begin
    if (reset_sync || clr_stats) begin
      match_count <= {CNT_W{1'b0}};
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (accept && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
      if (fifo_drop) begin
        overflow <= 1'b1;
      end
      if (to_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  ts_fifo #(
    .WIDTH (TS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ts_fifo (
    .clk        (clk),
    .reset_sync (reset_sync),
    .push       (accept),
    .din        (timestamp),
    .pop        (rd_en),
    .dout       (ts_dout),
    .valid      (ts_valid),
    .full       (fifo_full),
    .drop       (fifo_drop)
  );

endmodule
